// File: rtl/lf_adder_pkg.sv
// Shared types and the prefix operator for the Ladner-Fischer adder.
package lf_adder_pkg;

  localparam int LFA_WIDTH  = 32;
  localparam int LFA_LEVELS = $clog2(LFA_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant span
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/lf_prefix_cell.sv
// One prefix node. A grey cell (GREY=1) sits where the span already reaches
// bit 0, so only the group generate is meaningful and P is tied low.
module lf_prefix_cell
  import lf_adder_pkg::*;
#(
  parameter bit GREY = 1'b0
) (
  input  pg_t hi,
  input  pg_t lo,
  output pg_t pg
);

  if (GREY) begin : g_grey
    logic unused_lo_p;
    assign pg.g        = hi.g | (hi.p & lo.g);
    assign pg.p        = 1'b0;
    assign unused_lo_p = lo.p;
  end else begin : g_black
    assign pg = pg_combine(hi, lo);
  end

endmodule

// File: rtl/lf_adder.sv
// Registered Ladner-Fischer prefix adder: s_list/c = a + b (+ cin), 1-cycle latency.
// Optional carry-in port enabled by defining LFA_CIN_EN.
module lf_adder
  import lf_adder_pkg::*;
#(
  parameter int WIDTH = LFA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef LFA_CIN_EN
  input  logic             cin,
`endif
  output logic [WIDTH-1:0] s_list,
  output logic             c
);

  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lf_adder: WIDTH must be a power of two in 2..64");
  end

  // lvl[l][i] is node i entering level l; lvl[LEVELS][i].g = G[i:0]
  pg_t lvl [LEVELS+1][WIDTH];

  logic             cin_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] unused_p;
  logic [WIDTH-1:0] s_next;
  logic             c_next;

`ifdef LFA_CIN_EN
  assign cin_bit = cin;
`else
  assign cin_bit = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg
    if (i == 0) begin : g_lsb
      // carry-in folded into bit 0 so the tree sees it as a generate
      assign lvl[0][0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin_bit);
    end else begin : g_other
      assign lvl[0][i].g = a[i] & b[i];
    end
    assign lvl[0][i].p = a[i] ^ b[i];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (((i >> l) & 1) == 1) begin : g_cell
        localparam int J = ((i >> l) << l) - 1;
        lf_prefix_cell #(
          .GREY((i >> (l + 1)) == 0)
        ) u_cell (
          .hi(lvl[l][i]),
          .lo(lvl[l][J]),
          .pg(lvl[l+1][i])
        );
      end else begin : g_buf
        assign lvl[l+1][i] = lvl[l][i];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_tap
    assign p_bit[i]    = lvl[0][i].p;
    assign g_pre[i]    = lvl[LEVELS][i].g;
    assign unused_p[i] = lvl[LEVELS][i].p;
  end

  assign s_next = p_bit ^ {g_pre[WIDTH-2:0], cin_bit};
  assign c_next = g_pre[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_list <= '0;
      c      <= 1'b0;
    end else begin
      s_list <= s_next;
      c      <= c_next;
    end
  end

endmodule

// File: tb/tb_lf_adder.sv
// Scoreboard bench for lf_adder: driver queues hand-computed results, monitor checks them.
module tb_lf_adder;

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
`ifdef LFA_CIN_EN
  logic        cin;
`endif
  logic [31:0] s_list;
  logic        c;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  lf_adder #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
`ifdef LFA_CIN_EN
    .cin   (cin),
`endif
    .s_list(s_list),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got_s, input logic got_c,
                       input logic [31:0] want_s, input logic want_c);
    checks++;
    if (got_s !== want_s || got_c !== want_c) begin
      errors++;
      $display("FAIL %s: got s_list=%h c=%b, want s_list=%h c=%b",
               name, got_s, got_c, want_s, want_c);
    end
  endtask

  // drive at negedge; result expected after the following posedge
  task automatic apply(input string name, input logic [31:0] va, input logic [31:0] vb,
                       input logic vcin, input logic [31:0] ws, input logic wc);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
`ifdef LFA_CIN_EN
    cin = vcin;
`else
    if (vcin) $display("note: cin ignored in this build");
`endif
    e.name = name;
    e.s    = ws;
    e.c    = wc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, s_list, c, e.s, e.c);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    a     = 32'h1234_5678;
    b     = 32'h0f0f_0f0f;
`ifdef LFA_CIN_EN
    cin   = 1'b0;
`endif
    #1;
    check("reset_state", s_list, c, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_edge", s_list, c, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("random_pair", 32'h3a6f36e3, 32'hf6af8732, 1'b0, 32'h311ebe15, 1'b1);
    apply("full_chain",  32'hffffffff, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
    apply("alt_bits",    32'haaaaaaaa, 32'h55555555, 1'b0, 32'hffffffff, 1'b0);
    apply("msb_carry",   32'h7fffffff, 32'h00000001, 1'b0, 32'h80000000, 1'b0);

    // asynchronous reset mid-stream with nonzero inputs
    @(posedge clk);
    #3;
    a     = 32'hdead_beef;
    b     = 32'h1111_1111;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", s_list, c, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("async_reset_edge", s_list, c, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.name = "after_release";
      e.s    = 32'hefbe_d000;
      e.c    = 1'b0;
      exp_q.push_back(e);
    end

    apply("b2b_zero", 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    apply("b2b_one",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0);
    apply("b2b_msb",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
    apply("mixed",    32'h0000ffff, 32'h00010001, 1'b0, 32'h00020000, 1'b0);
`ifdef LFA_CIN_EN
    apply("cin_full", 32'hffffffff, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    apply("cin_only", 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0);
`endif

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
